reg_alu_seq: RTL
================

REG_ALU_SEQ -- requirements
Module: reg_alu_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  instruction offered.
REQ-005 SHALL have port in_ready  output  1  instruction accepted when in_valid and in_ready are both high at a rising edge.
REQ-006 SHALL have port in_op  input  3  ALU operation code.
REQ-007 SHALL have ports in_rd, in_rs1, in_rs2  input  3 each  destination, source A and source B register addresses.
REQ-008 SHALL have port in_wb  input  1  1 = write the result back, 0 = compute only.
REQ-009 SHALL have port alu_cout  input  1  ALU carry-out for the current operation.
REQ-010 SHALL have ports rd_addr_a, rd_addr_b  output  3 each  register-file read addresses.
REQ-011 SHALL have port alu_op  output  3  ALU operation select.
REQ-012 SHALL have ports wr  output  1, and wr_addr  output  3  register-file write enable and write address.
REQ-013 SHALL have port flag_c  output  1  carry flag from the last written-back instruction.
REQ-014 SHALL have ports busy  output  1, done  output  1, and instr_cnt  output  CNT_W.

Function
REQ-015 SHALL implement a four-state FSM with states IDLE, READ, EXEC and WRITE.
REQ-016 SHALL use these transitions: IDLE->READ on accept; READ->EXEC; EXEC->WRITE; WRITE->READ on accept; WRITE->IDLE otherwise.
REQ-017 SHALL assert in_ready only in IDLE and WRITE.
REQ-018 SHALL latch in_op, in_rd, in_rs1, in_rs2 and in_wb on accept, and hold them until the next accept.
REQ-019 SHALL drive rd_addr_a = rs1, rd_addr_b = rs2 and alu_op = op, stable throughout READ, EXEC and WRITE.
REQ-020 SHALL drive rd_addr_a, rd_addr_b, alu_op and wr_addr to 0 in IDLE.
REQ-021 SHALL assert wr for exactly the one WRITE cycle, only when the latched wb = 1, with wr_addr = rd; wr SHALL be 0 in all other states.
REQ-022 SHALL pulse done high for one cycle in every WRITE state, regardless of wb.
REQ-023 SHALL register flag_c from alu_cout at the end of a WRITE cycle only when wb = 1; otherwise flag_c holds its value.
REQ-024 SHALL drive busy high in READ, EXEC and WRITE, and low in IDLE.
REQ-025 SHALL, for an instruction accepted at edge N, assert wr/done during cycle N+3 (latency 3); back-to-back throughput SHALL be one instruction per 3 cycles.
REQ-026 SHALL need no forwarding when the next instruction's rs1/rs2 equals the previous rd: the write commits at the end of WRITE, before the following READ.
REQ-027 SHALL accept an instruction with rd = rs1 = rs2, with no special handling.
REQ-028 SHALL, when in_valid is high outside IDLE/WRITE, ignore the offered instruction and leave in_valid held by the requester.

Reset
REQ-029 SHALL, on reset assertion at any time (including mid-instruction), immediately force state IDLE, wr = 0, done = 0, busy = 0, flag_c = 0, all address/op outputs = 0 and instr_cnt = 0, and discard the in-flight instruction with no write.
REQ-030 SHALL drive in_ready = 1 while reset is asserted and in the first cycle after release.

Configuration
REQ-031 SHALL, with macro REG_ALU_SEQ_CNT_EN defined, increment instr_cnt by 1 on each done pulse, wrapping from 2^CNT_W-1 to 0.
REQ-032 SHALL, with REG_ALU_SEQ_CNT_EN undefined, tie instr_cnt to constant 0 and compile in no counter flops.

Verification
REQ-033 SHALL cover: reset, then op=3, rd=5, rs1=1, rs2=2, wb=1 accepted at edge 0 -> rd_addr_a=1, rd_addr_b=2 in cycles 1-3; wr=1, wr_addr=5, done=1 in cycle 3 only.
REQ-034 SHALL cover: in_valid held high with 3 instructions -> accepts at edges 0, 3, 6; three done pulses at cycles 3, 6, 9; busy never drops between them.
REQ-035 SHALL cover: wb=0 instruction with alu_cout=1 -> done=1, wr=0, flag_c unchanged (0).
REQ-036 SHALL cover: reset asserted during EXEC -> outputs zero immediately, no wr pulse, instr_cnt unchanged at 0.
REQ-037 SHALL cover: instr 1 writes rd=4, instr 2 reads rs1=4 back-to-back -> instr 2 READ cycle occurs after the instr 1 write edge.
REQ-038 SHALL cover, with REG_ALU_SEQ_CNT_EN defined and CNT_W=2: 5 instructions -> instr_cnt sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/reg_alu_seq.sv
// reg_alu_seq: sequencer for a register-file + ALU datapath.
// Each accepted instruction walks IDLE/WRITE -> READ -> EXEC -> WRITE. The
// register-file write and the done pulse happen in WRITE, three cycles after
// the instruction is accepted.
// All outputs come straight from flops. Each output register is loaded from
// the next-state and next-field values, so it lines up with the state it
// belongs to.
// Optional feature: define REG_ALU_SEQ_CNT_EN to enable the retired-instruction
// counter (instr_cnt). When the macro is undefined, instr_cnt is tied to 0.
module reg_alu_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [2:0]       in_rd,
    input  logic [2:0]       in_rs1,
    input  logic [2:0]       in_rs2,
    input  logic             in_wb,
    input  logic             alu_cout,
    output logic [2:0]       rd_addr_a,
    output logic [2:0]       rd_addr_b,
    output logic [2:0]       alu_op,
    output logic             wr,
    output logic [2:0]       wr_addr,
    output logic             flag_c,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t     state_r;
    state_t     state_s;

    // Latched instruction fields, held from one accept to the next
    logic [2:0] op_r;
    logic [2:0] rd_r;
    logic [2:0] rs1_r;
    logic [2:0] rs2_r;
    logic       wb_r;

    // Field values that will be current after the next edge
    logic [2:0] op_s;
    logic [2:0] rd_s;
    logic [2:0] rs1_s;
    logic [2:0] rs2_s;
    logic       wb_s;

    // Output registers and their next values
    logic       in_ready_r;
    logic       busy_r;
    logic       done_r;
    logic       wr_r;
    logic [2:0] rd_addr_a_r;
    logic [2:0] rd_addr_b_r;
    logic [2:0] alu_op_r;
    logic [2:0] wr_addr_r;
    logic       flag_c_r;

    logic       in_ready_s;
    logic       busy_s;
    logic       done_s;
    logic       wr_s;
    logic [2:0] rd_addr_a_s;
    logic [2:0] rd_addr_b_s;
    logic [2:0] alu_op_s;
    logic [2:0] wr_addr_s;

    logic       accept_s;

    // in_ready_r is high exactly in IDLE and WRITE (and during reset)
    assign accept_s = in_valid & in_ready_r;

    // Next-state logic for the instruction sequencer
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                state_s = EXEC;
            end
            EXEC: begin
                state_s = WRITE;
            end
            WRITE: begin
                if (accept_s) begin
                    state_s = READ;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Select freshly accepted fields or keep the latched ones
    always_comb begin
        op_s  = op_r;
        rd_s  = rd_r;
        rs1_s = rs1_r;
        rs2_s = rs2_r;
        wb_s  = wb_r;
        if (accept_s) begin
            op_s  = in_op;
            rd_s  = in_rd;
            rs1_s = in_rs1;
            rs2_s = in_rs2;
            wb_s  = in_wb;
        end else begin
            op_s  = op_r;
            rd_s  = rd_r;
            rs1_s = rs1_r;
            rs2_s = rs2_r;
            wb_s  = wb_r;
        end
    end

    // Decode the output values that belong to the next state
    always_comb begin
        in_ready_s  = 1'b0;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        wr_s        = 1'b0;
        rd_addr_a_s = 3'd0;
        rd_addr_b_s = 3'd0;
        alu_op_s    = 3'd0;
        wr_addr_s   = 3'd0;
        case (state_s)
            IDLE: begin
                in_ready_s = 1'b1;
            end
            READ, EXEC: begin
                busy_s      = 1'b1;
                rd_addr_a_s = rs1_s;
                rd_addr_b_s = rs2_s;
                alu_op_s    = op_s;
                wr_addr_s   = rd_s;
            end
            WRITE: begin
                in_ready_s  = 1'b1;
                busy_s      = 1'b1;
                done_s      = 1'b1;
                wr_s        = wb_s;
                rd_addr_a_s = rs1_s;
                rd_addr_b_s = rs2_s;
                alu_op_s    = op_s;
                wr_addr_s   = rd_s;
            end
            default: begin
                in_ready_s = 1'b1;
            end
        endcase
    end

    // State register and latched instruction fields
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            op_r    <= 3'd0;
            rd_r    <= 3'd0;
            rs1_r   <= 3'd0;
            rs2_r   <= 3'd0;
            wb_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            op_r    <= op_s;
            rd_r    <= rd_s;
            rs1_r   <= rs1_s;
            rs2_r   <= rs2_s;
            wb_r    <= wb_s;
        end
    end

    // Registered outputs; reset parks in IDLE with in_ready high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            wr_r        <= 1'b0;
            rd_addr_a_r <= 3'd0;
            rd_addr_b_r <= 3'd0;
            alu_op_r    <= 3'd0;
            wr_addr_r   <= 3'd0;
        end else begin
            in_ready_r  <= in_ready_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            wr_r        <= wr_s;
            rd_addr_a_r <= rd_addr_a_s;
            rd_addr_b_r <= rd_addr_b_s;
            alu_op_r    <= alu_op_s;
            wr_addr_r   <= wr_addr_s;
        end
    end

    // Carry flag captures alu_cout as a write-back instruction retires
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_c_r <= 1'b0;
        end else if ((state_r == WRITE) && wb_r) begin
            flag_c_r <= alu_cout;
        end else begin
            flag_c_r <= flag_c_r;
        end
    end

`ifdef REG_ALU_SEQ_CNT_EN
    logic [CNT_W-1:0] instr_cnt_r;

    // Retired-instruction counter, counts each done pulse and wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_cnt_r <= {CNT_W{1'b0}};
        end else if (done_r) begin
            instr_cnt_r <= instr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            instr_cnt_r <= instr_cnt_r;
        end
    end

    assign instr_cnt = instr_cnt_r;
`else
    assign instr_cnt = {CNT_W{1'b0}};
`endif

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign wr        = wr_r;
    assign rd_addr_a = rd_addr_a_r;
    assign rd_addr_b = rd_addr_b_r;
    assign alu_op    = alu_op_r;
    assign wr_addr   = wr_addr_r;
    assign flag_c    = flag_c_r;

endmodule
